// File: rtl/ahb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
// Shared encodings for the two-master AHB arbiter slice: HTRANS and HRESP
// codes, master IDs driven onto hmaster/hmaster_data, and the arbiter state
// type with its two ownership states.
// ---------------------------------------------------------------------------
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  localparam logic [1:0] MST1 = 2'b00;
  localparam logic [1:0] MST2 = 2'b01;

  // Ownership state; kept as plain constants so older tools that mangle
  // enums still see the same encoding.
  typedef logic [0:0] state_t;
  localparam state_t OWN_M1 = 1'b0;
  localparam state_t OWN_M2 = 1'b1;

  // Bus ID of the master that owns the bus in a given state.
  function automatic logic [1:0] master_id(state_t s);
    return (s == OWN_M2) ? MST2 : MST1;
  endfunction

  // The opposite owner, used when the grant is handed across.
  function automatic state_t other_owner(state_t s);
    return (s == OWN_M1) ? OWN_M2 : OWN_M1;
  endfunction

  // Any non-OKAY response ends the current owner's claim on the bus.
  function automatic logic resp_aborts(logic [1:0] resp);
    return resp != HRESP_OKAY;
  endfunction

endpackage

// File: rtl/ahb_arbiter_if.sv
// ---------------------------------------------------------------------------
// ahb_arbiter_if
// Bundles the arbitration signals shared between the bus masters and the
// arbiter.
//   hbusreq1/2   : bus requests from master 1 / master 2
//   htrans       : muxed transfer type of the address-phase owner
//   hready/hresp : shared slave-side completion and response
//   hgrant1/2    : registered grants
//   hmaster      : address-phase owner ID
//   hmaster_data : data-phase owner ID
// Modport slave is the arbiter's view; modport master is the bus side that
// drives requests and observes grants.
// ---------------------------------------------------------------------------
interface ahb_arbiter_if;

  logic       hbusreq1;
  logic       hbusreq2;
  logic [1:0] htrans;
  logic       hready;
  logic [1:0] hresp;
  logic       hgrant1;
  logic       hgrant2;
  logic [1:0] hmaster;
  logic [1:0] hmaster_data;

  modport slave (
    input  hbusreq1, hbusreq2, htrans, hready, hresp,
    output hgrant1, hgrant2, hmaster, hmaster_data
  );

  modport master (
    output hbusreq1, hbusreq2, htrans, hready, hresp,
    input  hgrant1, hgrant2, hmaster, hmaster_data
  );

endinterface

// File: rtl/ahb_arbiter_tenure_cnt.sv
// ---------------------------------------------------------------------------
// ahb_arb_tenure_cnt
// Counts accepted transfers of the current bus tenure and saturates at
// TENURE_MAX.
//   hclk, hresetn : clock, asynchronous active-low reset
//   count_en      : an accepted NONSEQ/SEQ transfer this cycle
//   clear         : grant changes on this edge; takes priority over count_en
//   limit         : counter has reached TENURE_MAX
// ---------------------------------------------------------------------------
module ahb_arb_tenure_cnt #(
  parameter int TENURE_MAX = 8
) (
  input  logic hclk,
  input  logic hresetn,
  input  logic count_en,
  input  logic clear,
  output logic limit
);

  localparam logic [3:0] CNT_MAX = 4'(TENURE_MAX);

  logic [3:0] count_q;

  // Clear wins over increment so a new owner always starts its tenure at
  // zero; once at CNT_MAX the counter stays put until the grant moves.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      count_q <= 4'd0;
    end else if (clear) begin
      count_q <= 4'd0;
    end else if (count_en && (count_q != CNT_MAX)) begin
      count_q <= count_q + 4'd1;
    end
  end

  assign limit = (count_q == CNT_MAX);

endmodule

// File: rtl/ahb_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_arbiter
// Two-master round-robin AHB arbiter with a tenure limit.
//   hclk, hresetn : clock, asynchronous active-low reset
//   bus           : ahb_arbiter_if.slave (requests, htrans, hready, hresp in;
//                   grants, hmaster, hmaster_data out)
// Parameter TENURE_MAX (2..15) bounds the transfers one master may issue
// while the other master is waiting.
// ---------------------------------------------------------------------------
module ahb_arbiter #(
  parameter int TENURE_MAX = 8
) (
  input  logic             hclk,
  input  logic             hresetn,
  ahb_arbiter_if.slave     bus
);

  import ahb_pkg::*;

  state_t     state;
  state_t     next_state;
  logic [1:0] hmaster_q;
  logic [1:0] hmaster_data_q;
  logic       owner_req;
  logic       other_req;
  logic       tenure_limit;
  logic       handover;
  logic       count_en;
  logic       grant_change;

  // The current owner is also the last owner for round-robin purposes, so
  // no separate last-owner register is needed.
  always_comb begin
    owner_req = (state == OWN_M1) ? bus.hbusreq1 : bus.hbusreq2;
    other_req = (state == OWN_M1) ? bus.hbusreq2 : bus.hbusreq1;
  end

  // A handover point needs a completed cycle plus a reason to let go: a
  // transfer boundary, the owner dropping its request, an aborting response,
  // or the tenure limit with the other master waiting (even mid-burst).
  always_comb begin
    handover = bus.hready &&
               ((bus.htrans == HTRANS_IDLE) ||
                (bus.htrans == HTRANS_NONSEQ) ||
                !owner_req ||
                resp_aborts(bus.hresp) ||
                (tenure_limit && other_req));
  end

  // At a handover point the waiting master wins ties; with nobody
  // requesting, the bus parks on master 1.
  always_comb begin
    next_state = state;
    if (handover) begin
      if (other_req) begin
        next_state = other_owner(state);
      end else if (owner_req) begin
        next_state = state;
      end else begin
        next_state = OWN_M1;
      end
    end
  end

  // Ownership and the address/data owner pipeline only advance on cycles
  // where the slave accepts the transfer; a stall freezes all three.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state          <= OWN_M1;
      hmaster_q      <= MST1;
      hmaster_data_q <= MST1;
    end else if (bus.hready) begin
      state          <= next_state;
      hmaster_q      <= master_id(next_state);
      hmaster_data_q <= hmaster_q;
    end
  end

  assign count_en     = bus.hready &&
                        ((bus.htrans == HTRANS_NONSEQ) || (bus.htrans == HTRANS_SEQ));
  assign grant_change = (next_state != state);

  ahb_arb_tenure_cnt #(
    .TENURE_MAX (TENURE_MAX)
  ) u_tenure (
    .hclk     (hclk),
    .hresetn  (hresetn),
    .count_en (count_en),
    .clear    (grant_change),
    .limit    (tenure_limit)
  );

  assign bus.hgrant1      = (state == OWN_M1);
  assign bus.hgrant2      = (state == OWN_M2);
  assign bus.hmaster      = hmaster_q;
  assign bus.hmaster_data = hmaster_data_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ahb_arbiter
// Self-checking bench for ahb_arbiter with TENURE_MAX=8: a table of directed
// single-cycle vectors plus hand-written multi-cycle sequences for bursts,
// tenure limit, saturation, alternation and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_ahb_arbiter;

  import ahb_pkg::*;

  localparam int NUM_VECS = 16;

  typedef struct {
    logic       req1;
    logic       req2;
    logic [1:0] trans;
    logic       rdy;
    logic [1:0] resp;
    logic       g1;
    logic       g2;
    logic [1:0] hm;
    logic [1:0] hmd;
  } vec_t;

  logic hclk;
  logic hresetn;
  int   totalChecks;
  int   errorCount;
  logic monitorOn;
  vec_t vecs [NUM_VECS];

  ahb_arbiter_if bus ();

  ahb_arbiter #(
    .TENURE_MAX (8)
  ) dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .bus     (bus)
  );

  // Free-running clock, period 10.
  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  // Exactly one grant must be high whenever reset is released.
  always @(negedge hclk) begin
    if (monitorOn && hresetn) begin
      totalChecks++;
      if ((bus.hgrant1 ^ bus.hgrant2) !== 1'b1) begin
        errorCount++;
        $display("[TB] FAIL onehot_grant: got hgrant1=%b hgrant2=%b expected exactly one high",
                 bus.hgrant1, bus.hgrant2);
      end
    end
  end

  task automatic compare(input string name, input string what, input int act, input int exp);
    totalChecks++;
    if (act != exp) begin
      errorCount++;
      $display("[TB] FAIL %s: %s got %0d expected %0d", name, what, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic g1, input logic g2,
                             input logic [1:0] hm, input logic [1:0] hmd);
    compare(name, "hgrant1", int'(bus.hgrant1), int'(g1));
    compare(name, "hgrant2", int'(bus.hgrant2), int'(g2));
    compare(name, "hmaster", int'(bus.hmaster), int'(hm));
    compare(name, "hmaster_data", int'(bus.hmaster_data), int'(hmd));
  endtask

  task automatic checkTenure(input string name, input int exp);
    compare(name, "tenure_count", int'(dut.u_tenure.count_q), exp);
  endtask

  task automatic setInputs(input logic r1, input logic r2, input logic [1:0] tr,
                           input logic rdy, input logic [1:0] rsp);
    bus.hbusreq1 = r1;
    bus.hbusreq2 = r2;
    bus.htrans   = tr;
    bus.hready   = rdy;
    bus.hresp    = rsp;
  endtask

  task automatic applyStimulus(input vec_t v);
    setInputs(v.req1, v.req2, v.trans, v.rdy, v.resp);
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  // Asserts reset away from any clock edge, checks the asynchronous reset
  // values, then releases one cycle later just after a rising edge.
  task automatic doReset(input string name);
    setInputs(1'b0, 1'b0, HTRANS_IDLE, 1'b1, HRESP_OKAY);
    hresetn = 1'b0;
    #2;
    checkOutput(name, 1'b1, 1'b0, MST1, MST1);
    checkTenure(name, 0);
    @(posedge hclk);
    #1;
    hresetn = 1'b1;
  endtask

  initial begin
    totalChecks = 0;
    errorCount  = 0;
    monitorOn   = 1'b0;
    hresetn     = 1'b1;
    setInputs(1'b0, 1'b0, HTRANS_IDLE, 1'b1, HRESP_OKAY);

    vecs[0]  = '{1'b0, 1'b1, HTRANS_IDLE,   1'b1, HRESP_OKAY,  1'b0, 1'b1, MST2, MST1};
    vecs[1]  = '{1'b0, 1'b1, HTRANS_NONSEQ, 1'b1, HRESP_OKAY,  1'b0, 1'b1, MST2, MST2};
    vecs[2]  = '{1'b1, 1'b1, HTRANS_SEQ,    1'b0, HRESP_OKAY,  1'b0, 1'b1, MST2, MST2};
    vecs[3]  = '{1'b1, 1'b1, HTRANS_SEQ,    1'b0, HRESP_ERROR, 1'b0, 1'b1, MST2, MST2};
    vecs[4]  = '{1'b1, 1'b1, HTRANS_SEQ,    1'b1, HRESP_ERROR, 1'b1, 1'b0, MST1, MST2};
    vecs[5]  = '{1'b1, 1'b0, HTRANS_NONSEQ, 1'b1, HRESP_OKAY,  1'b1, 1'b0, MST1, MST1};
    vecs[6]  = '{1'b0, 1'b0, HTRANS_SEQ,    1'b1, HRESP_OKAY,  1'b1, 1'b0, MST1, MST1};
    vecs[7]  = '{1'b0, 1'b1, HTRANS_SEQ,    1'b0, HRESP_OKAY,  1'b1, 1'b0, MST1, MST1};
    vecs[8]  = '{1'b0, 1'b1, HTRANS_SEQ,    1'b0, HRESP_OKAY,  1'b1, 1'b0, MST1, MST1};
    vecs[9]  = '{1'b0, 1'b1, HTRANS_SEQ,    1'b1, HRESP_OKAY,  1'b0, 1'b1, MST2, MST1};
    vecs[10] = '{1'b0, 1'b0, HTRANS_IDLE,   1'b1, HRESP_OKAY,  1'b1, 1'b0, MST1, MST2};
    vecs[11] = '{1'b0, 1'b1, HTRANS_SEQ,    1'b1, HRESP_OKAY,  1'b0, 1'b1, MST2, MST1};
    vecs[12] = '{1'b1, 1'b1, HTRANS_SEQ,    1'b1, HRESP_OKAY,  1'b0, 1'b1, MST2, MST2};
    vecs[13] = '{1'b0, 1'b1, HTRANS_NONSEQ, 1'b1, HRESP_OKAY,  1'b0, 1'b1, MST2, MST2};
    vecs[14] = '{1'b1, 1'b1, HTRANS_BUSY,   1'b1, HRESP_RETRY, 1'b1, 1'b0, MST1, MST2};
    vecs[15] = '{1'b1, 1'b0, HTRANS_IDLE,   1'b1, HRESP_SPLIT, 1'b1, 1'b0, MST1, MST1};

    #3;
    doReset("reset_initial");
    monitorOn = 1'b1;

    // Idle bus after reset: parked on master 1.
    for (int c = 0; c < 10; c++) begin
      step();
      checkOutput($sformatf("idle_park%0d", c), 1'b1, 1'b0, MST1, MST1);
    end

    // Directed single-cycle vectors, each applied from the previous state.
    for (int i = 0; i < NUM_VECS; i++) begin
      applyStimulus(vecs[i]);
      step();
      checkOutput($sformatf("vec%0d", i), vecs[i].g1, vecs[i].g2, vecs[i].hm, vecs[i].hmd);
    end

    // Master 1 four-beat burst with master 2 waiting: grant held through the
    // SEQ beats, handed over at the following IDLE.
    doReset("reset_burst");
    setInputs(1'b1, 1'b0, HTRANS_NONSEQ, 1'b1, HRESP_OKAY);
    step();
    checkOutput("burst_beat1", 1'b1, 1'b0, MST1, MST1);
    for (int b = 2; b <= 4; b++) begin
      setInputs(1'b1, 1'b1, HTRANS_SEQ, 1'b1, HRESP_OKAY);
      step();
      checkOutput($sformatf("burst_beat%0d", b), 1'b1, 1'b0, MST1, MST1);
    end
    setInputs(1'b1, 1'b1, HTRANS_IDLE, 1'b1, HRESP_OKAY);
    step();
    checkOutput("burst_switch", 1'b0, 1'b1, MST2, MST1);

    // Long burst with master 2 waiting: the tenure limit forces a handover
    // on the edge after the 8th accepted transfer.
    doReset("reset_tenure");
    setInputs(1'b1, 1'b0, HTRANS_NONSEQ, 1'b1, HRESP_OKAY);
    step();
    checkTenure("tenure_beat1", 1);
    for (int b = 2; b <= 8; b++) begin
      setInputs(1'b1, 1'b1, HTRANS_SEQ, 1'b1, HRESP_OKAY);
      step();
      checkOutput($sformatf("tenure_beat%0d", b), 1'b1, 1'b0, MST1, MST1);
    end
    checkTenure("tenure_at_max", 8);
    setInputs(1'b1, 1'b1, HTRANS_SEQ, 1'b1, HRESP_OKAY);
    step();
    checkOutput("tenure_handover", 1'b0, 1'b1, MST2, MST1);
    checkTenure("tenure_cleared", 0);

    // Nobody waiting: the counter saturates and the limit is ignored until
    // master 2 starts requesting.
    doReset("reset_saturate");
    setInputs(1'b1, 1'b0, HTRANS_NONSEQ, 1'b1, HRESP_OKAY);
    step();
    for (int b = 0; b < 11; b++) begin
      setInputs(1'b1, 1'b0, HTRANS_SEQ, 1'b1, HRESP_OKAY);
      step();
    end
    checkTenure("sat_count", 8);
    checkOutput("sat_hold", 1'b1, 1'b0, MST1, MST1);
    setInputs(1'b1, 1'b1, HTRANS_SEQ, 1'b1, HRESP_OKAY);
    step();
    checkOutput("sat_limit_switch", 1'b0, 1'b1, MST2, MST1);

    // Both masters requesting single NONSEQ transfers: strict alternation.
    doReset("reset_alt");
    for (int k = 1; k <= 5; k++) begin
      setInputs(1'b1, 1'b1, HTRANS_NONSEQ, 1'b1, HRESP_OKAY);
      step();
      if ((k % 2) == 1) begin
        checkOutput($sformatf("alt%0d", k), 1'b0, 1'b1, MST2, MST1);
      end else begin
        checkOutput($sformatf("alt%0d", k), 1'b1, 1'b0, MST1, MST2);
      end
    end

    // Reset pulse between edges forces master 1 at once; the first edge
    // after release arbitrates from the reset state.
    #2;
    hresetn = 1'b0;
    #1;
    checkOutput("async_reset", 1'b1, 1'b0, MST1, MST1);
    checkTenure("async_reset", 0);
    #2;
    hresetn = 1'b1;
    step();
    checkOutput("post_reset_arb", 1'b0, 1'b1, MST2, MST1);

    $display("Simulation finished: %0d checks, %0d errors", totalChecks, errorCount);
    $finish;
  end

endmodule
